// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time capture with sample-buffer addressing (optional PWM_CAP_DEGLITCH_EN majority filter)
module pwm_capture #(
   parameter int PERIOD = 256,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cap_en,
   input  logic              pwm_i,
   output logic [15:0]       sample_o,
   output logic              sample_vld,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              buf_wrap,
   output logic              busy
);

   localparam logic [15:0]       LAST_CYC = 16'(PERIOD - 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ALIGN   = 2'd1,
      MEASURE = 2'd2
   } state_t;

   state_t      state;
   logic        pwm_meta;
   logic        pwm_s;
   logic        pwm_f;
   logic        pwm_prev;
   logic        rise;
   logic [15:0] frame_cnt;
   logic [15:0] high_cnt;
   logic [15:0] high_sum;

   // two-flop synchronizer bringing the asynchronous PWM input into the clk domain
   always_ff @(posedge clk) begin
      if (!rstn) begin
         pwm_meta <= 1'b0;
         pwm_s    <= 1'b0;
      end else begin
         pwm_meta <= pwm_i;
         pwm_s    <= pwm_meta;
      end
   end

`ifdef PWM_CAP_DEGLITCH_EN
   logic tap1;
   logic tap2;

   // 3-tap majority vote over the synchronized stream; a lone 1-cycle glitch never wins the vote
   always_ff @(posedge clk) begin
      if (!rstn) begin
         tap1  <= 1'b0;
         tap2  <= 1'b0;
         pwm_f <= 1'b0;
      end else begin
         tap1  <= pwm_s;
         tap2  <= tap1;
         pwm_f <= (pwm_s & tap1) | (pwm_s & tap2) | (tap1 & tap2);
      end
   end
`else
   assign pwm_f = pwm_s;
`endif

   // previous filtered level, used only for rising-edge alignment
   always_ff @(posedge clk) begin
      if (!rstn) begin
         pwm_prev <= 1'b0;
      end else begin
         pwm_prev <= pwm_f;
      end
   end

   assign rise     = pwm_f & ~pwm_prev;
   // high_cnt never exceeds PERIOD-1 before this add, so 16 bits cannot overflow
   assign high_sum = high_cnt + {15'd0, pwm_f};

   // capture FSM: align to a rising edge, then count back-to-back frames and strobe each result
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         frame_cnt  <= '0;
         high_cnt   <= '0;
         sample_o   <= '0;
         sample_vld <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         buf_wrap   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         sample_vld <= 1'b0;
         wr_en      <= 1'b0;
         buf_wrap   <= 1'b0;
         // the address is held for the write cycle and advances right after it
         if (wr_en) begin
            wr_addr <= wr_addr + 1'b1;
         end
         case (state)
            IDLE: begin
               if (cap_en) begin
                  state <= ALIGN;
                  busy  <= 1'b1;
               end
            end
            ALIGN: begin
               if (!cap_en) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  frame_cnt <= '0;
                  high_cnt  <= '0;
                  wr_addr   <= '0;
               end else if (rise) begin
                  // the edge cycle is frame cycle 0 and its bit (always 1) is counted
                  state     <= MEASURE;
                  frame_cnt <= 16'd1;
                  high_cnt  <= 16'd1;
               end
            end
            MEASURE: begin
               if (frame_cnt == LAST_CYC) begin
                  // frame completes even if cap_en falls on this very cycle
                  sample_o   <= high_sum;
                  sample_vld <= 1'b1;
                  wr_en      <= 1'b1;
                  buf_wrap   <= (wr_addr == ADDR_MAX);
                  frame_cnt  <= '0;
                  high_cnt   <= '0;
                  if (!cap_en) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else if (!cap_en) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  frame_cnt <= '0;
                  high_cnt  <= '0;
                  wr_addr   <= '0;
               end else begin
                  frame_cnt <= frame_cnt + 16'd1;
                  high_cnt  <= high_sum;
               end
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               frame_cnt <= '0;
               high_cnt  <= '0;
            end
         endcase
      end
   end

endmodule
